// File: rtl/rx_packet_ctrl.sv
// rtl/rx_packet_ctrl.sv - sequencer for the serial RX shift buffer: bit strobes, clear, capture, delivery
module rx_packet_ctrl #(
  parameter int PACKET_SIZE = 24,
  parameter int DIV_W       = 8,
  parameter int MAX_BITS    = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_rx_mode,
  input  logic                   i_config,
  input  logic [DIV_W-1:0]       i_div,
  input  logic [PACKET_SIZE-1:0] i_sr_data,
  input  logic                   i_sr_pkt_rec,
  output logic                   o_sr_en,
  output logic                   o_sr_pkt_rst,
  output logic [PACKET_SIZE-1:0] o_pkt_data,
  output logic                   o_pkt_valid,
  input  logic                   i_pkt_ready,
  output logic                   o_busy,
  output logic [7:0]             o_resync_cnt
);

  localparam int BIT_W = $clog2(MAX_BITS + 1);
  localparam logic [BIT_W-1:0] BITS_MAX = BIT_W'(MAX_BITS);
  localparam logic [BIT_W-1:0] BITS_PKT = BIT_W'(PACKET_SIZE);
  localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(2);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLEAR   = 2'd1,
    ST_HUNT    = 2'd2,
    ST_DELIVER = 2'd3
  } state_t;

  state_t                 r_state;
  logic [DIV_W-1:0]       r_div_cnt;
  logic [BIT_W-1:0]       r_bit_cnt;
  logic [7:0]             r_resync_cnt;
  logic                   r_sr_pkt_rst;
  logic                   r_pkt_valid;
  logic                   r_busy;
  logic [PACKET_SIZE-1:0] r_pkt_data;

  logic [DIV_W-1:0]       w_div_max;
  logic                   w_abort;
  logic                   w_in_hunt;
  logic                   w_div_hit;
  logic                   w_sr_en;
  logic                   w_detect;
  logic                   w_timeout;

  // The flag lags a shift by 2 clk, so a period shorter than 3 clk could shift past a detection.
  assign w_div_max = (i_div < DIV_MIN) ? DIV_MIN : i_div;
  assign w_abort   = i_config | ~i_rx_mode;
  assign w_in_hunt = (r_state == ST_HUNT);
  assign w_div_hit = (r_div_cnt == w_div_max);
  // Shifting stops while a detection is pending so the captured word cannot move under us.
  assign w_sr_en   = w_in_hunt & w_div_hit & ~i_sr_pkt_rec;
  // Flags seen before a full packet has shifted are stale leftovers from the previous packet.
  assign w_detect  = w_in_hunt & i_sr_pkt_rec & (r_bit_cnt >= BITS_PKT);
  assign w_timeout = w_in_hunt & (r_bit_cnt == BITS_MAX) & ~w_detect;

  assign o_sr_en      = w_sr_en;
  assign o_sr_pkt_rst = r_sr_pkt_rst;
  assign o_pkt_data   = r_pkt_data;
  assign o_pkt_valid  = r_pkt_valid;
  assign o_busy       = r_busy;
  assign o_resync_cnt = r_resync_cnt;

  // Bit-period divider and strobe counter; both only run in HUNT and restart from zero on entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
    end else if (!w_in_hunt) begin
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
    end else begin
      // A count already past a newly lowered limit wraps without producing a strobe.
      if (r_div_cnt >= w_div_max) begin
        r_div_cnt <= '0;
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
      if (w_sr_en && (r_bit_cnt != BITS_MAX)) begin
        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
      end
    end
  end

  // Packet sequencer with registered clear pulse, valid, busy and resync counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_sr_pkt_rst <= 1'b0;
      r_pkt_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_pkt_data   <= '0;
      r_resync_cnt <= '0;
    end else begin
      r_sr_pkt_rst <= 1'b0;
      if (w_abort) begin
        r_state     <= ST_IDLE;
        r_pkt_valid <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state      <= ST_CLEAR;
            r_sr_pkt_rst <= 1'b1;
            r_busy       <= 1'b1;
          end
          ST_CLEAR: begin
            r_state <= ST_HUNT;
            r_busy  <= 1'b1;
          end
          ST_HUNT: begin
            r_busy <= 1'b1;
            if (w_detect) begin
              r_pkt_data  <= i_sr_data;
              r_pkt_valid <= 1'b1;
              r_state     <= ST_DELIVER;
            end else if (w_timeout) begin
              r_state      <= ST_CLEAR;
              r_sr_pkt_rst <= 1'b1;
              if (r_resync_cnt != 8'hFF) begin
                r_resync_cnt <= r_resync_cnt + 8'd1;
              end
            end
          end
          ST_DELIVER: begin
            r_busy <= 1'b1;
            if (i_pkt_ready) begin
              r_pkt_valid  <= 1'b0;
              r_state      <= ST_CLEAR;
              r_sr_pkt_rst <= 1'b1;
            end
          end
          default: begin
            r_state     <= ST_IDLE;
            r_pkt_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
